// File: rtl/gpio_bus_arbiter.sv
// Two-master round-robin arbiter sharing one GPIO register port.
// Turns per-master req/ack commands into registered ADDRESS/WRITE/WDATA cycles.
module gpio_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Handshake: a master raises req with we/addr/wdata and holds all of them
  // stable until it samples ack=1; ack is a one-cycle pulse (err/rdata valid
  // with it), and req must be 0 (or a fresh request) in the cycle after ack.
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] gpio_address,
  output logic                  gpio_write,
  output logic [DATA_WIDTH-1:0] gpio_wdata,
  input  logic [DATA_WIDTH-1:0] gpio_rdata,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] gpio_address_q, gpio_address_d;
  logic                  gpio_write_q, gpio_write_d;
  logic [DATA_WIDTH-1:0] gpio_wdata_q, gpio_wdata_d;
  logic                  m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic                  m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic                  busy_q, busy_d;

  logic                  sel;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // 0x000 is read-only; 0x004 and 0x008 are read/write; all else is rejected.
  function automatic logic is_legal(input logic we, input logic [ADDR_WIDTH-1:0] addr);
    is_legal = (addr == ADDR_WIDTH'(32'h4)) || (addr == ADDR_WIDTH'(32'h8)) ||
               ((addr == '0) && !we);
  endfunction

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    grant_d        = grant_q;
    we_d           = we_q;
    gpio_address_d = gpio_address_q;
    gpio_write_d   = gpio_write_q;
    gpio_wdata_d   = gpio_wdata_q;
    m0_rdata_d     = m0_rdata_q;
    m1_rdata_d     = m1_rdata_q;
    m0_ack_d       = 1'b0;
    m1_ack_d       = 1'b0;
    m0_err_d       = 1'b0;
    m1_err_d       = 1'b0;

    // Tie goes to whichever master was not served last.
    if (m0_req && m1_req) sel = ~last_grant_q;
    else                  sel = m1_req;
    sel_we    = sel ? m1_we    : m0_we;
    sel_addr  = sel ? m1_addr  : m0_addr;
    sel_wdata = sel ? m1_wdata : m0_wdata;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_d      = sel;
          last_grant_d = sel;
          we_d         = sel_we;
          if (is_legal(sel_we, sel_addr)) begin
            gpio_address_d = sel_addr;
            gpio_write_d   = sel_we;
            gpio_wdata_d   = sel_wdata;
            state_d        = ISSUE;
          end else begin
            m0_ack_d = ~sel;
            m1_ack_d = sel;
            m0_err_d = ~sel;
            m1_err_d = sel;
            state_d  = DONE;
          end
        end
      end
      ISSUE: begin
        gpio_address_d = '0;
        gpio_write_d   = 1'b0;
        gpio_wdata_d   = '0;
        if (we_q) begin
          m0_ack_d = ~grant_q;
          m1_ack_d = grant_q;
          state_d  = DONE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (grant_q) m1_rdata_d = gpio_rdata;
        else         m0_rdata_d = gpio_rdata;
        m0_ack_d = ~grant_q;
        m1_ack_d = grant_q;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      grant_q        <= 1'b0;
      we_q           <= 1'b0;
      gpio_address_q <= '0;
      gpio_write_q   <= 1'b0;
      gpio_wdata_q   <= '0;
      m0_ack_q       <= 1'b0;
      m1_ack_q       <= 1'b0;
      m0_err_q       <= 1'b0;
      m1_err_q       <= 1'b0;
      m0_rdata_q     <= '0;
      m1_rdata_q     <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant_q        <= grant_d;
      we_q           <= we_d;
      gpio_address_q <= gpio_address_d;
      gpio_write_q   <= gpio_write_d;
      gpio_wdata_q   <= gpio_wdata_d;
      m0_ack_q       <= m0_ack_d;
      m1_ack_q       <= m1_ack_d;
      m0_err_q       <= m0_err_d;
      m1_err_q       <= m1_err_d;
      m0_rdata_q     <= m0_rdata_d;
      m1_rdata_q     <= m1_rdata_d;
      busy_q         <= busy_d;
    end
  end

  assign m0_ack       = m0_ack_q;
  assign m0_err       = m0_err_q;
  assign m0_rdata     = m0_rdata_q;
  assign m1_ack       = m1_ack_q;
  assign m1_err       = m1_err_q;
  assign m1_rdata     = m1_rdata_q;
  assign gpio_address = gpio_address_q;
  assign gpio_write   = gpio_write_q;
  assign gpio_wdata   = gpio_wdata_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;

endmodule
